relay_station_fifo: RTL and testbench
=====================================

# relay_station_fifo

Parametrised relay station: a DEPTH-entry register FIFO that breaks every combinational path between its slave (upstream) and master (downstream) valid/ready interfaces. It is a generalisation of the single-stage relay station, adding:
- configurable data width and depth;
- sustained one-beat-per-cycle throughput under arbitrary backpressure;
- an occupancy count and an almost-full flag;
- a synchronous flush.

It is inserted on long or timing-critical streaming paths between pipeline stages.

## Interface
Parameters:
- DW, 8: data width in bits.
- DEPTH, 4: number of entries; power of two, minimum 2.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset; assertion clears state immediately, deassertion sampled on clk.
- flush  in  1  synchronous flush; empties the FIFO at the next edge.
- valid_s  in  1  upstream beat valid.
- ready_s  out  1  upstream ready.
- data_s  in  DW  upstream data.
- valid_m  out  1  downstream beat valid.
- ready_m  in  1  downstream ready.
- data_m  out  DW  downstream data.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.

## Operation
- Storage: DEPTH x DW register array, write pointer wp and read pointer rp of $clog2(DEPTH) bits, each wrapping modulo DEPTH; separate occupancy counter count.
- push = valid_s & ready_s; pop = valid_m & ready_m.
- ready_s = (count != DEPTH). valid_m = (count != 0). data_m = mem[rp]. almost_full = (count >= AF_LEVEL). All of these are functions of registered state only. No combinational path exists from valid_s, data_s or ready_m to any output.
- On push: mem[wp] <= data_s; wp <= wp+1.
- On pop: rp <= rp+1.
- count update: push only: +1; pop only: -1; push and pop together: unchanged.
- A simultaneous push and pop is legal at any occupancy from 1 to DEPTH-1.
  - When empty, only a push can occur.
  - When full, only a pop can occur, because ready_s=0.
- Ordering: strict FIFO; no beat is duplicated, dropped or reordered, except by flush.
- flush=1 at an edge:
  - wp, rp and count are all set to 0.
  - Any push in that cycle is discarded.
  - A pop in that cycle is treated as delivered, because downstream has sampled it.
  - Memory contents are not cleared.
- Overflow and underflow cannot occur by construction. The bench asserts count never leaves 0..DEPTH.

## Timing
- Reset values while rst_n=0: ready_s=1, valid_m=0, count=0, almost_full=0 if AF_LEVEL>0, wp=rp=0. data_m holds an undefined value that is stable and don't-care.
- Latency: a beat pushed at edge k appears on valid_m/data_m in the cycle after edge k (1 cycle) when the FIFO is empty.
- Throughput: with valid_s=1 and ready_m=1 held, count settles at 1 and one beat transfers per cycle indefinitely.
- Backpressure: after ready_m drops, the FIFO absorbs DEPTH beats. ready_s falls in the cycle after the push that reaches count=DEPTH.
- ready_s rises in the cycle after the first pop from full.
- Reset mid-operation: the asynchronous assertion clears all state within the same cycle. The first push is accepted at the first edge after deassertion. No stale beat appears on valid_m.
- flush and a push in the same cycle leave the FIFO empty, not holding one beat.

## Test plan
- Reset: hold rst_n=0 for 10 cycles with valid_s=1 -> valid_m=0, ready_s=1, count=0 throughout. First beat (data 0x00) appears on data_m one cycle after the first post-reset edge.
- Streaming: DW=8, DEPTH=4, valid_s=ready_m=1, data incrementing 0..254 -> data_m delivers 0..254 in order, one per cycle, with no bubbles after the first; count stays at 1.
- Fill/drain: ready_m=0, push 6 beats offered -> exactly 4 accepted (0..3). ready_s=0 from the cycle after the 4th push. almost_full=1 at count=3. Then ready_m=1 -> 0,1,2,3 out; beat 4 accepted the cycle after the first pop.
- Random: 10k cycles of random valid_s/ready_m at 50% each, for DEPTH=2 and DEPTH=8 -> the scoreboard matches every beat in order, count equals pushes minus pops, and count stays within 0..DEPTH.
- Flush: with 3 beats held and valid_s=1, assert flush for 1 cycle -> next cycle count=0, valid_m=0. The beat offered during flush is lost. The following beats resume in order.
- Async reset mid-stream: drop rst_n between edges while count=2 -> valid_m=0 and count=0 before the next edge. After release, streaming resumes with no stale data.

Source files
------------

// File: rtl/relay_station_fifo.sv
// Relay station FIFO: DEPTH-entry register FIFO placed between two valid/ready
// interfaces. Every output is decoded from registered state only, so no
// combinational path crosses the block in either direction. Full throughput is
// kept under arbitrary backpressure. The block also reports occupancy, raises an
// almost-full flag and supports a synchronous flush.
module relay_station_fifo #(
  parameter int unsigned DW       = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         valid_s,
  output logic                         ready_s,
  input  logic [DW-1:0]                data_s,
  output logic                         valid_m,
  input  logic                         ready_m,
  output logic [DW-1:0]                data_m,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Interface outputs decoded purely from registered state.
  always_comb begin
    ready_s     = (count_q != CW'(DEPTH));
    valid_m     = (count_q != '0);
    data_m      = mem_q[rp_q];
    almost_full = (count_q >= CW'(AF_LEVEL));
    count       = count_q;
  end

  // Handshakes. Each one uses only the local output, which is a registered value.
  always_comb begin
    push = valid_s & ready_s;
    pop  = valid_m & ready_m;
  end

  // Next-state pointers and occupancy. Flush wins over any push. A pop in the
  // flush cycle counts as delivered, so the FIFO simply ends up empty.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Data storage. It is never reset, and a push that coincides with flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wp_q] <= data_s;
    end
  end

endmodule

// File: tb/tb_relay_station_fifo.sv
// Testbench for relay_station_fifo. It drives three instances (DEPTH 4, 2 and 8)
// with shared stimulus. Each instance has its own monitor. On the input side the
// monitor records accepted beats into a queue. On the output side it pops the
// queue and compares each delivered beat. The queue size is the expected
// occupancy.
module tb_relay_station_fifo;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          valid_s = 1'b0;
  logic [DW-1:0] data_s = '0;
  logic          ready_m = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned D  = (g == 0) ? 4 : ((g == 1) ? 2 : 8);
    localparam int unsigned CW = $clog2(D + 1);

    logic          ready_s;
    logic          valid_m;
    logic [DW-1:0] data_m;
    logic [CW-1:0] cnt;
    logic          af;
    logic [DW-1:0] q[$];

    relay_station_fifo #(
      .DW      (DW),
      .DEPTH   (D),
      .AF_LEVEL(D - 1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .valid_s    (valid_s),
      .ready_s    (ready_s),
      .data_s     (data_s),
      .valid_m    (valid_m),
      .ready_m    (ready_m),
      .data_m     (data_m),
      .count      (cnt),
      .almost_full(af)
    );

    // Reset drops every beat still in flight.
    always @(negedge rst_n) q.delete();

    // Monitor: sample between edges, check state, then apply the coming edge's transfers.
    always @(negedge clk) begin : p_mon
      int unsigned n;
      logic        push, pop;
      #1;
      n = q.size();
      check($sformatf("d%0d_count", D), 32'(cnt), n);
      check($sformatf("d%0d_count_range", D), 32'(32'(cnt) <= D), 1);
      check($sformatf("d%0d_valid_m", D), 32'(valid_m), 32'(n != 0));
      check($sformatf("d%0d_ready_s", D), 32'(ready_s), 32'(n != D));
      check($sformatf("d%0d_almost_full", D), 32'(af), 32'(n >= D - 1));
      if (rst_n) begin
        push = valid_s & ready_s;
        pop  = valid_m & ready_m;
        if (pop) begin
          check($sformatf("d%0d_pop_nonempty", D), 32'(q.size() != 0), 1);
          if (q.size() != 0) check($sformatf("d%0d_data_m", D), 32'(data_m), 32'(q[0]));
        end
        if (flush) begin
          q.delete();
        end else begin
          if (pop && q.size() != 0) void'(q.pop_front());
          if (push) q.push_back(data_s);
        end
      end
    end
  end

  task automatic drain(input int cycles);
    valid_s = 1'b0;
    ready_m = 1'b1;
    flush   = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin : p_drive
    int k;
    int acc;

    // Reset held with valid_s asserted: nothing may be accepted.
    rst_n   = 1'b0;
    valid_s = 1'b1;
    ready_m = 1'b1;
    data_s  = '0;
    repeat (10) @(negedge clk);
    #1 check("reset_ready_s", 32'(g_dut[0].ready_s), 1);

    // Streaming 0..254 with no backpressure.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 255; i++) begin
      data_s = 8'(i);
      @(negedge clk);
      if (i == 0) begin
        #1;
        check("first_beat_valid", 32'(g_dut[0].valid_m), 1);
        check("first_beat_data", 32'(g_dut[0].data_m), 0);
      end
    end
    drain(12);

    // Fill against backpressure. The data only advances when instance 0 accepts it.
    ready_m = 1'b0;
    valid_s = 1'b1;
    k       = 0;
    acc     = 0;
    repeat (6) begin
      if (acc == 3) check("af_at_3", 32'(g_dut[0].af), 1);
      data_s = 8'(k);
      if (g_dut[0].ready_s) begin
        k++;
        acc++;
      end
      @(negedge clk);
    end
    check("fill_accepted", 32'(acc), 4);
    check("fill_ready_s_low", 32'(g_dut[0].ready_s), 0);
    ready_m = 1'b1;
    data_s  = 8'(k);
    @(negedge clk);
    check("ready_s_after_first_pop", 32'(g_dut[0].ready_s), 1);
    for (int i = 0; i < 6; i++) begin
      if (g_dut[0].ready_s) k++;
      data_s = 8'(k);
      @(negedge clk);
    end
    drain(12);

    // Flush with 3 beats held and a beat on offer.
    ready_m = 1'b0;
    valid_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_s = 8'(8'h20 + i);
      @(negedge clk);
    end
    check("pre_flush_count", 32'(g_dut[0].cnt), 3);
    data_s = 8'hA5;
    flush  = 1'b1;
    @(negedge clk);
    flush   = 1'b0;
    valid_s = 1'b0;
    #1;
    check("flush_count", 32'(g_dut[0].cnt), 0);
    check("flush_valid_m", 32'(g_dut[0].valid_m), 0);
    ready_m = 1'b1;
    valid_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_s = 8'(8'h30 + i);
      @(negedge clk);
    end
    drain(12);

    // Asynchronous reset between edges while two beats are held.
    ready_m = 1'b0;
    valid_s = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_s = 8'(8'h40 + i);
      @(negedge clk);
    end
    check("pre_reset_count", 32'(g_dut[0].cnt), 2);
    data_s = 8'h42;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_count", 32'(g_dut[0].cnt), 0);
    check("async_reset_valid_m", 32'(g_dut[0].valid_m), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    ready_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_s = 8'(8'h50 + i);
      @(negedge clk);
    end
    drain(12);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      valid_s = 1'($urandom_range(0, 1));
      ready_m = 1'($urandom_range(0, 1));
      data_s  = 8'($urandom);
      flush   = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    drain(12);

    check("end_empty_d4", 32'(g_dut[0].q.size()), 0);
    check("end_empty_d2", 32'(g_dut[1].q.size()), 0);
    check("end_empty_d8", 32'(g_dut[2].q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
